// File: rtl/issue_ctrl.sv
// Issue controller: scoreboard-based RAW/WAW hazard detection between decode and execute,
// with an in-flight write cap, a registered execute slot and a stall-cycle counter.
module issue_ctrl #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        uses_rs1,
    input  logic        uses_rs2,
    input  logic [4:0]  rd,
    input  logic        rd_write,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_write,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] busy,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    logic [31:0] busy_q;
    logic [3:0]  inflight_q;
    logic        ex_valid_q;
    logic [4:0]  ex_rd_q;
    logic        ex_rd_write_q;
    logic [31:0] stall_q;

    logic        slot_free;
    logic        rd_tracked;
    logic        hazard;
    logic        full;
    logic        issue;
    logic        set_busy;
    logic        retire;
    logic [31:0] busy_next;
    logic [3:0]  inflight_next;

    // Hazards look only at registered busy bits, so a writeback never bypasses into issue.
    always_comb begin
        slot_free  = !ex_valid_q || ex_ready;
        rd_tracked = rd_write && (rd != 5'd0);
        hazard     = (uses_rs1 && (rs1 != 5'd0) && busy_q[rs1])
                  || (uses_rs2 && (rs2 != 5'd0) && busy_q[rs2])
                  || (rd_tracked && busy_q[rd]);
        full       = rd_tracked && (inflight_q == MAX_CNT);
        issue      = !reset && id_valid && slot_free && !hazard && !full && !flush;
        set_busy   = issue && rd_tracked;
        retire     = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];

        busy_next     = busy_q;
        inflight_next = inflight_q;
        if (set_busy) begin
            busy_next = busy_next | (32'd1 << rd);
        end
        if (retire) begin
            busy_next = busy_next & ~(32'd1 << wb_rd);
        end
        case ({set_busy, retire})
            2'b10:   inflight_next = inflight_q + 4'd1;
            2'b01:   inflight_next = inflight_q - 4'd1;
            default: inflight_next = inflight_q;
        endcase
    end

    // Flush discards tracking and the held slot but keeps the stall count.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q        <= 32'd0;
            inflight_q    <= 4'd0;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= 5'd0;
            ex_rd_write_q <= 1'b0;
            stall_q       <= 32'd0;
        end else if (flush) begin
            busy_q     <= 32'd0;
            inflight_q <= 4'd0;
            ex_valid_q <= 1'b0;
        end else begin
            busy_q     <= busy_next;
            inflight_q <= inflight_next;
            if (issue) begin
                ex_valid_q    <= 1'b1;
                ex_rd_q       <= rd;
                ex_rd_write_q <= rd_write;
            end else if (ex_ready) begin
                ex_valid_q <= 1'b0;
            end
            if (id_valid && !issue) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign id_ready     = issue;
    assign ex_valid     = ex_valid_q;
    assign ex_rd        = ex_rd_q;
    assign ex_rd_write  = ex_rd_write_q;
    assign busy         = busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: a small reference model predicts id_ready and state,
// and a scoreboard queue matches issued destinations against what execute consumes.
module tb_issue_ctrl;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_rd_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] busy;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_busy;
    int          m_inflight;
    logic        m_exv;
    logic [31:0] m_stall;
    logic [5:0]  sb[$];
    logic        last_ready;

    issue_ctrl #(.MAX_INFLIGHT(MAX)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .rs1(rs1), .rs2(rs2), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .rd(rd), .rd_write(rd_write),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_rd_write(ex_rd_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Issue rule evaluated against the model's registered state.
    function automatic logic model_ready();
        logic haz;
        logic trk;
        trk = rd_write && (rd != 5'd0);
        haz = (uses_rs1 && (rs1 != 5'd0) && m_busy[rs1])
           || (uses_rs2 && (rs2 != 5'd0) && m_busy[rs2])
           || (trk && m_busy[rd]);
        return !reset && id_valid && (!m_exv || ex_ready) && !haz
            && !(trk && (m_inflight == MAX)) && !flush;
    endfunction

    task automatic idle();
        flush    = 1'b0;
        id_valid = 1'b0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        rd       = 5'd0;
        rd_write = 1'b0;
        ex_ready = 1'b1;
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
    endtask

    task automatic setWrite(input logic [4:0] r);
        id_valid = 1'b1;
        rd       = r;
        rd_write = 1'b1;
    endtask

    task automatic setWb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
    endtask

    // One clock: check combinational id_ready, consume/record the scoreboard, advance the model.
    task automatic applyStimulus();
        logic       exp_rdy;
        logic       retire;
        logic [5:0] front;
        #1;
        exp_rdy    = model_ready();
        last_ready = id_ready;
        checkOutput("id_ready", 32'(id_ready), 32'(exp_rdy));
        if (!reset && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
                front = sb.pop_front();
                checkOutput("ex_dest", 32'({ex_rd_write, ex_rd}), 32'(front));
            end
        end
        if (exp_rdy) sb.push_back({rd_write, rd});
        @(posedge clk);
        if (reset) begin
            m_busy = 32'd0; m_inflight = 0; m_exv = 1'b0; m_stall = 32'd0;
            sb.delete();
        end else if (flush) begin
            m_busy = 32'd0; m_inflight = 0; m_exv = 1'b0;
            sb.delete();
        end else begin
            retire = wb_valid && (wb_rd != 5'd0) && m_busy[wb_rd];
            if (retire) begin
                m_busy[wb_rd] = 1'b0;
                m_inflight--;
            end
            if (exp_rdy && rd_write && (rd != 5'd0)) begin
                m_busy[rd] = 1'b1;
                m_inflight++;
            end
            if (exp_rdy) m_exv = 1'b1;
            else if (ex_ready) m_exv = 1'b0;
            if (id_valid && !exp_rdy) m_stall = m_stall + 32'd1;
        end
        @(negedge clk);
        checkOutput("busy", busy, m_busy);
        checkOutput("stall_cycles", stall_cycles, m_stall);
        checkOutput("ex_valid", 32'(ex_valid), 32'(m_exv));
    endtask

    initial begin
        logic [31:0] s0;
        m_busy = 32'd0; m_inflight = 0; m_exv = 1'b0; m_stall = 32'd0;
        last_ready = 1'b0;

        // Reset, with decode presenting a write that must not issue.
        idle();
        reset = 1'b1;
        setWrite(5'd1);
        applyStimulus();
        checkOutput("reset_ready", 32'(last_ready), 32'd0);
        applyStimulus();
        checkOutput("reset_busy", busy, 32'd0);
        checkOutput("reset_exv", 32'(ex_valid), 32'd0);
        checkOutput("reset_exrd", 32'({ex_rd_write, ex_rd}), 32'd0);
        checkOutput("reset_stall", stall_cycles, 32'd0);
        reset = 1'b0;

        // Independent stream x1..x3, then writebacks.
        for (int i = 1; i <= 3; i++) begin
            idle();
            setWrite(5'(i));
            applyStimulus();
            checkOutput("indep_ready", 32'(last_ready), 32'd1);
            checkOutput("indep_busy", busy, (32'd1 << (i + 1)) - 32'd2);
        end
        for (int i = 1; i <= 3; i++) begin
            idle();
            setWb(5'(i));
            applyStimulus();
        end
        checkOutput("indep_clear", busy, 32'd0);

        // RAW stall on x5, released the cycle after its writeback.
        idle(); setWrite(5'd5); applyStimulus();
        idle(); setWrite(5'd8); rs1 = 5'd5; uses_rs1 = 1'b1;
        s0 = stall_cycles;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("raw_stall", 32'(last_ready), 32'd0);
        end
        checkOutput("raw_stall_cnt", stall_cycles, s0 + 32'd3);
        setWb(5'd5);
        applyStimulus();
        checkOutput("raw_wb_same", 32'(last_ready), 32'd0);
        wb_valid = 1'b0;
        applyStimulus();
        checkOutput("raw_wb_next", 32'(last_ready), 32'd1);
        idle(); setWb(5'd8); applyStimulus();

        // WAW on x7, and x0 never hazards or becomes busy.
        idle(); setWrite(5'd7); applyStimulus();
        applyStimulus();
        checkOutput("waw_stall", 32'(last_ready), 32'd0);
        idle(); setWb(5'd7); applyStimulus();
        idle(); setWrite(5'd0); rs1 = 5'd0; uses_rs1 = 1'b1;
        applyStimulus();
        checkOutput("x0_issue", 32'(last_ready), 32'd1);
        checkOutput("x0_busy0", 32'(busy[0]), 32'd0);

        // In-flight cap.
        for (int i = 1; i <= 4; i++) begin
            idle(); setWrite(5'(i)); applyStimulus();
            checkOutput("cap_fill", 32'(last_ready), 32'd1);
        end
        idle(); setWrite(5'd6); applyStimulus();
        checkOutput("cap_full", 32'(last_ready), 32'd0);
        idle(); id_valid = 1'b1; rs1 = 5'd9; uses_rs1 = 1'b1; rd = 5'd9;
        applyStimulus();
        checkOutput("cap_readonly", 32'(last_ready), 32'd1);
        idle(); setWrite(5'd6); setWb(5'd2); applyStimulus();
        checkOutput("cap_wb_same", 32'(last_ready), 32'd0);
        wb_valid = 1'b0;
        applyStimulus();
        checkOutput("cap_release", 32'(last_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle(); setWb(i == 0 ? 5'd1 : (i == 1 ? 5'd3 : (i == 2 ? 5'd4 : 5'd6)));
            applyStimulus();
        end
        checkOutput("cap_clear", busy, 32'd0);

        // Execute backpressure.
        idle(); setWrite(5'd10); applyStimulus();
        idle(); ex_ready = 1'b0; setWrite(5'd11);
        applyStimulus();
        checkOutput("bp_stall", 32'(last_ready), 32'd0);
        applyStimulus();
        checkOutput("bp_hold_v", 32'(ex_valid), 32'd1);
        checkOutput("bp_hold_rd", 32'(ex_rd), 32'd10);
        ex_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_release", 32'(last_ready), 32'd1);
        checkOutput("bp_new_rd", 32'(ex_rd), 32'd11);
        idle(); setWb(5'd10); applyStimulus();
        idle(); setWb(5'd11); applyStimulus();

        // Flush with x1..x3 busy, slot held and a writeback in the flush cycle.
        for (int i = 1; i <= 3; i++) begin
            idle(); setWrite(5'(i)); applyStimulus();
        end
        idle(); flush = 1'b1; ex_ready = 1'b0; setWb(5'd1); setWrite(5'd12);
        s0 = stall_cycles;
        applyStimulus();
        checkOutput("flush_ready", 32'(last_ready), 32'd0);
        checkOutput("flush_busy", busy, 32'd0);
        checkOutput("flush_exv", 32'(ex_valid), 32'd0);
        checkOutput("flush_stall", stall_cycles, s0);
        for (int i = 1; i <= 4; i++) begin
            idle(); setWrite(5'(i)); applyStimulus();
            checkOutput("flush_inflight0", 32'(last_ready), 32'd1);
        end
        idle(); setWrite(5'd6); applyStimulus();
        checkOutput("flush_cap", 32'(last_ready), 32'd0);

        // Reset mid-flight also clears the stall count.
        idle(); reset = 1'b1; setWrite(5'd6);
        applyStimulus();
        checkOutput("midreset_ready", 32'(last_ready), 32'd0);
        checkOutput("midreset_busy", busy, 32'd0);
        checkOutput("midreset_exv", 32'(ex_valid), 32'd0);
        checkOutput("midreset_stall", stall_cycles, 32'd0);
        reset = 1'b0;

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            idle();
            id_valid = 1'($urandom_range(0, 1));
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            uses_rs1 = 1'($urandom_range(0, 1));
            uses_rs2 = 1'($urandom_range(0, 1));
            rd       = 5'($urandom_range(0, 7));
            rd_write = 1'($urandom_range(0, 1));
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 39) == 0);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
